// File: rtl/fifo_pop_stage_if.sv
// Handshake bundle between the FIFO controller/memory, fifo_pop_stage and the downstream consumer.
// The master modport is the pop stage; the slave modport is the environment around it.
interface fifo_pop_stage_if #(
  parameter int unsigned WIDTH = 8
);
  logic             fifo_empty;
  logic             fifo_pop;
  logic [WIDTH-1:0] mem_rd_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    input  fifo_empty,
    input  mem_rd_data,
    input  out_ready,
    output fifo_pop,
    output out_valid,
    output out_data
  );

  modport slave (
    output fifo_empty,
    output mem_rd_data,
    output out_ready,
    input  fifo_pop,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/fifo_pop_stage.sv
// Pops the FIFO controller, tracks memory read latency and buffers returned words into a
// valid/ready stream. Optional synchronous flush input under `FIFO_POP_STAGE_FLUSH_EN.
module fifo_pop_stage #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
`ifdef FIFO_POP_STAGE_FLUSH_EN
  input  logic             flush,
`endif
  fifo_pop_stage_if.master bus
);

  localparam int unsigned BUF_DEPTH = RD_LATENCY + 1;
  localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PTR_W     = $clog2(BUF_DEPTH);

  logic                  flush_w;
  logic                  deq;
  logic                  pop;
  logic                  wr_en;

  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [OCC_W-1:0]      cnt_q, cnt_d;
  logic [RD_LATENCY-1:0] infl_q, infl_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;
  logic [WIDTH-1:0]      mem_q [BUF_DEPTH];

`ifdef FIFO_POP_STAGE_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign deq   = out_valid_q && bus.out_ready;
  assign wr_en = infl_q[RD_LATENCY-1];
  // occ already counts every in-flight word, so a return can never overrun the buffer.
  assign pop   = !reset && !flush_w && !bus.fifo_empty &&
                 ((occ_q < OCC_W'(BUF_DEPTH)) || deq);

  assign bus.fifo_pop  = pop;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  always_comb begin
    occ_d       = occ_q + OCC_W'(pop) - OCC_W'(deq);
    infl_d      = (infl_q << 1) | RD_LATENCY'(pop);
    wr_ptr_d    = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d       = cnt_q + OCC_W'(wr_en) - OCC_W'(deq);
    out_valid_d = (cnt_d != '0);
    out_data_d  = out_data_q;
    // The slot being written is the new head only when it becomes the sole buffered word.
    if (cnt_d != '0) begin
      out_data_d = (wr_en && (wr_ptr_q == rd_ptr_d)) ? bus.mem_rd_data : mem_q[rd_ptr_d];
    end
    if (flush_w) begin
      occ_d       = '0;
      infl_d      = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q       <= '0;
      cnt_q       <= '0;
      infl_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      occ_q       <= occ_d;
      cnt_q       <= cnt_d;
      infl_q      <= infl_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush_w && wr_en) begin
      mem_q[wr_ptr_q] <= bus.mem_rd_data;
    end
  end

endmodule

// File: tb/tb_fifo_pop_stage.sv
// Scoreboard bench for fifo_pop_stage: a queue-based FIFO/memory model feeds the DUT and a
// monitor checks every accepted word against the words popped since the last reset/flush.
module tb_fifo_pop_stage;

  localparam int unsigned W         = 8;
  localparam int unsigned RD_LAT    = 3;
  localparam int unsigned BUF_DEPTH = RD_LAT + 1;

  logic clk = 1'b0;
  logic reset;
  logic flush_s;

  fifo_pop_stage_if #(.WIDTH(W)) bus ();

  fifo_pop_stage #(
    .WIDTH      (W),
    .RD_LATENCY (RD_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
`ifdef FIFO_POP_STAGE_FLUSH_EN
    .flush (flush_s),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ready_mode = 0;  // 0: never ready, 1: always ready, 2: random 50%

  logic [W-1:0] src_q[$];      // words still inside the FIFO controller
  logic [W-1:0] exp_q[$];      // popped words the consumer is still owed
  logic [W-1:0] ret_data[int]; // memory return data keyed by cycle
  logic [W-1:0] env_w;
  logic [W-1:0] mon_w;
  int outstanding = 0;

  int pop_cnt, deq_cnt, valid_cnt;
  int first_pop, last_pop, first_valid, last_valid;

  function automatic void check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void clear_stats();
    pop_cnt     = 0;
    deq_cnt     = 0;
    valid_cnt   = 0;
    first_pop   = -1;
    last_pop    = -1;
    first_valid = -1;
    last_valid  = -1;
  endfunction

  // Start a new cycle: drive the controller/memory model outputs and the ready pattern.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    bus.fifo_empty = (src_q.size() == 0);
    if (ret_data.exists(cyc)) begin
      bus.mem_rd_data = ret_data[cyc];
      ret_data.delete(cyc);
    end else begin
      bus.mem_rd_data = W'($urandom);
    end
    case (ready_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Environment: FIFO controller and memory behaviour, credit bound.
  always @(negedge clk) begin
    if (reset) begin
      check("pop_in_reset", bus.fifo_pop, 0);
      src_q.delete();
      exp_q.delete();
      outstanding = 0;
    end else if (flush_s) begin
      check("pop_in_flush", bus.fifo_pop, 0);
      exp_q.delete();
      outstanding = 0;
    end else begin
      if (bus.fifo_empty) check("pop_while_empty", bus.fifo_pop, 0);
      if (bus.fifo_pop) begin
        if (src_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL pop_no_data: got pop expected none (cycle %0d)", cyc);
        end else begin
          env_w = src_q.pop_front();
          exp_q.push_back(env_w);
          ret_data[cyc + RD_LAT] = env_w;
        end
        pop_cnt++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      outstanding = outstanding + int'(bus.fifo_pop) - int'(bus.out_valid && bus.out_ready);
      check("occ_bound", outstanding <= BUF_DEPTH, 1);
    end
  end

  // Monitor: compare every accepted word with the scoreboard head.
  always @(negedge clk) begin
    if (!reset && !flush_s) begin
      if (bus.out_valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = cyc;
        last_valid = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        deq_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_word: got %0d expected none (cycle %0d)", bus.out_data, cyc);
        end else begin
          mon_w = exp_q.pop_front();
          check("out_data", bus.out_data, mon_w);
        end
      end
    end
  end

  initial begin
    reset           = 1'b1;
    flush_s         = 1'b0;
    bus.fifo_empty  = 1'b1;
    bus.mem_rd_data = '0;
    bus.out_ready   = 1'b0;
    clear_stats();

    repeat (3) step();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    reset = 1'b0;

    // Single word: exact pop-to-valid latency, one pop, one valid cycle.
    clear_stats();
    ready_mode = 1;
    src_q.push_back(8'hA5);
    repeat (RD_LAT + 6) step();
    check("single_pops", pop_cnt, 1);
    check("single_valid_cycles", valid_cnt, 1);
    check("single_latency", first_valid - first_pop, RD_LAT + 1);
    check("single_deq", deq_cnt, 1);

    // Streaming: one word per cycle, back-to-back pops and outputs.
    clear_stats();
    for (int i = 0; i < 16; i++) src_q.push_back(W'(i));
    repeat (16 + RD_LAT + 6) step();
    check("stream_pops", pop_cnt, 16);
    check("stream_deq", deq_cnt, 16);
    check("stream_pop_span", last_pop - first_pop, 15);
    check("stream_valid_span", last_valid - first_valid, 15);
    check("stream_valid_cycles", valid_cnt, 16);

    // Backpressure: credit limit on pops, head word held stable.
    clear_stats();
    ready_mode = 0;
    for (int i = 0; i < 10; i++) src_q.push_back(W'(8'h30 + i));
    repeat (20) step();
    check("bp_pops", pop_cnt, BUF_DEPTH);
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", bus.out_valid, 1);
      check("bp_data_stable", bus.out_data, 8'h30);
      step();
    end
    ready_mode = 1;
    repeat (30) step();
    check("bp_deq", deq_cnt, 10);
    check("bp_pops_total", pop_cnt, 10);
    check("bp_drained", exp_q.size(), 0);

    // Random ready and bursty source.
    clear_stats();
    ready_mode = 2;
    begin
      int pushed;
      pushed = 0;
      for (int c = 0; c < 5000 && deq_cnt < 200; c++) begin
        step();
        if (pushed < 200 && $urandom_range(0, 9) < 7) begin
          src_q.push_back(W'($urandom));
          pushed++;
        end
      end
    end
    ready_mode = 1;
    repeat (RD_LAT + 4) step();
    check("rand_deq", deq_cnt, 200);
    check("rand_pops", pop_cnt, 200);

    // Reset mid-stream: buffered and in-flight words are dropped.
    clear_stats();
    ready_mode = 0;
    for (int i = 0; i < 6; i++) src_q.push_back(W'(8'h50 + i));
    step();
    repeat (RD_LAT + 1) step();
    check("mid_valid_before_reset", bus.out_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_valid_after_reset", bus.out_valid, 0);
    check("mid_pop_after_reset", bus.fifo_pop, 0);
    ready_mode = 1;
    clear_stats();
    repeat (10) step();
    check("mid_no_stale", valid_cnt, 0);
    for (int i = 0; i < 3; i++) src_q.push_back(W'(8'h70 + i));
    repeat (RD_LAT + 8) step();
    check("mid_fresh_deq", deq_cnt, 3);

`ifdef FIFO_POP_STAGE_FLUSH_EN
    // Flush: in-flight returns ignored, later pops keep the normal latency.
    clear_stats();
    ready_mode = 0;
    for (int i = 0; i < 8; i++) src_q.push_back(W'(8'h90 + i));
    step();
    repeat (RD_LAT + 1) step();
    check("fl_valid_before", bus.out_valid, 1);
    flush_s = 1'b1;
    step();
    flush_s = 1'b0;
    check("fl_valid_after", bus.out_valid, 0);
    ready_mode = 1;
    clear_stats();
    repeat (20) step();
    check("fl_deq", deq_cnt, 8 - BUF_DEPTH);
    check("fl_latency", first_valid - first_pop, RD_LAT + 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
